// File: rtl/fb_write_port.sv
// fb_write_port: frame-buffer write port for the pixel-draw interface.
// Draw strobes are range-checked, converted to a linear address (y*H_RES+x)
// and queued in a FIFO. Entries drain to the frame-buffer write port only in
// cycles where the scanout arbiter grants access. A whole-screen fill
// operation can be started from IDLE.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   draw_en       draw strobe (one pixel offered per cycle, no backpressure)
//   draw_color    3-bit pixel color
//   draw_pos      [19:10]=x, [9:0]=y
//   fill_req      single-cycle pulse starting a full-screen fill
//   fill_color    fill color, sampled with fill_req
//   mem_grant     arbiter grant for this cycle
//   mem_we        frame-buffer write enable (registered)
//   mem_addr      write address (registered)
//   mem_wdata     write data (registered)
//   busy          FIFO non-empty, fill active or a write pending
//   fill_done     one-cycle pulse after the last fill write
//   overflow      sticky: a draw was dropped on a full FIFO
//
// Optional build macro: FB_WRITE_DEDUP_EN
//   When defined, a draw identical to the newest FIFO entry (still queued)
//   is dropped silently.
module fb_write_port #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              draw_en,
  input  logic [2:0]        draw_color,
  input  logic [19:0]       draw_pos,
  input  logic              fill_req,
  input  logic [2:0]        fill_color,
  input  logic              mem_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              busy,
  output logic              fill_done,
  output logic              overflow
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned NUM_PIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(NUM_PIX - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        color;
  } entry_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [2:0]        fill_color_q, fill_color_d;
  logic              fill_last_q, fill_last_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              fill_done_q, fill_done_d;
  logic              overflow_q, overflow_d;

  entry_t            fifo_q [FIFO_DEPTH];

  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              in_range;
  entry_t            in_entry;
  entry_t            head;
  logic              is_dup;
  logic              fifo_full;
  logic              pop;
  logic              want_push;
  logic              push;
  logic              drop;

  // Ingress decode: range check and linear address
  always_comb begin
    pos_x          = draw_pos[19:10];
    pos_y          = draw_pos[9:0];
    in_range       = (32'(pos_x) < H_RES) && (32'(pos_y) < V_RES);
    in_entry.addr  = ADDR_W'(pos_y) * ADDR_W'(H_RES) + ADDR_W'(pos_x);
    in_entry.color = draw_color;
    head           = fifo_q[rd_ptr_q];
  end

`ifdef FB_WRITE_DEDUP_EN
  // Newest pushed entry; it is still queued whenever the FIFO is non-empty
  entry_t last_q, last_d;

  always_comb begin
    last_d = push ? in_entry : last_q;
    is_dup = (count_q != '0) && (in_entry == last_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`else
  always_comb is_dup = 1'b0;
`endif

  // FIFO push/pop decisions; a full FIFO accepts only when popping too
  always_comb begin
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = (state_q == ST_IDLE) && (count_q != '0) && mem_grant;
    want_push = draw_en && in_range && !is_dup;
    push      = want_push && (!fifo_full || pop);
    drop      = want_push && fifo_full && !pop;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    fill_last_d  = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    overflow_d   = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = head.addr;
          mem_wdata_d = head.color;
        end
        if (fill_req) begin
          state_d      = ST_FILL;
          fill_cnt_d   = '0;
          fill_color_d = fill_color;
          overflow_d   = 1'b0;
        end
      end
      ST_FILL: begin
        if (mem_grant) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = fill_cnt_q;
          mem_wdata_d = fill_color_q;
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = ST_IDLE;
            fill_last_d = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the same cycle as a fill start still leaves overflow set
    if (drop) overflow_d = 1'b1;

    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    fill_done_d = fill_last_q;
    busy_d      = (count_d != '0) || (state_d == ST_FILL) || mem_we_d;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      fill_last_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      fill_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
      fill_last_q  <= fill_last_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      fill_done_q  <= fill_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_entry;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign fill_done = fill_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fb_write_port.sv
// tb_fb_write_port: directed and randomized bench for fb_write_port.
// V_RES is reduced to 8 lines so a complete fill stays short; H_RES keeps
// its nominal 640 so addresses match the nominal screen layout.
module tb_fb_write_port;

  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned ADDR_W     = 13;
  localparam int          NPIX       = H_RES * V_RES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              draw_en = 1'b0;
  logic [2:0]        draw_color = '0;
  logic [19:0]       draw_pos = '0;
  logic              fill_req = 1'b0;
  logic [2:0]        fill_color = '0;
  logic              mem_grant = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_wdata;
  logic              busy;
  logic              fill_done;
  logic              overflow;

  fb_write_port #(
    .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .draw_en(draw_en), .draw_color(draw_color),
    .draw_pos(draw_pos), .fill_req(fill_req), .fill_color(fill_color),
    .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .fill_done(fill_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending pixels, encoded as addr*8+color
  int mq[$];
  bit m_fill = 0, m_ovf = 0, m_we = 0, m_last = 0, m_done = 0, m_busy = 0;
  int m_idx = 0, m_fcol = 0, m_addr = 0, m_data = 0;
  int mx, my, me, mh;
  bit m_full, m_pop, m_take, m_set, m_dup;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_fill = 0; m_ovf = 0; m_we = 0; m_last = 0; m_done = 0; m_busy = 0;
      m_idx = 0; m_fcol = 0; m_addr = 0; m_data = 0;
    end else begin
      mx = int'(draw_pos[19:10]);
      my = int'(draw_pos[9:0]);
      m_full = (mq.size() == FIFO_DEPTH);
      m_pop  = !m_fill && (mq.size() != 0) && mem_grant;
      m_take = 0; m_set = 0; m_dup = 0;
      m_done = m_last;
      m_last = 0;
      m_we   = 0;
      me = 0;
      if (draw_en && mx < H_RES && my < V_RES) begin
        me = (my * H_RES + mx) * 8 + int'(draw_color);
`ifdef FB_WRITE_DEDUP_EN
        m_dup = (mq.size() != 0) && (mq[$] == me);
`endif
        if (!m_dup) begin
          if (m_full && !m_pop) m_set = 1;
          else                  m_take = 1;
        end
      end
      if (m_fill) begin
        if (mem_grant) begin
          m_we = 1; m_addr = m_idx; m_data = m_fcol;
          if (m_idx == NPIX - 1) begin m_fill = 0; m_last = 1; end
          else m_idx++;
        end
      end else begin
        if (m_pop) begin
          mh = mq.pop_front();
          m_we = 1; m_addr = mh / 8; m_data = mh % 8;
        end
        if (fill_req) begin
          m_fill = 1; m_idx = 0; m_fcol = int'(fill_color); m_ovf = 0;
        end
      end
      if (m_take) mq.push_back(me);
      if (m_set) m_ovf = 1;
      m_busy = (mq.size() != 0) || m_fill || m_we;
    end
  end

  // Per-cycle compare against the model plus a log of observed writes
  int obs[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", mem_we, m_we);
      if (m_we) begin
        chk("addr", mem_addr, m_addr);
        chk("wdata", mem_wdata, m_data);
      end
      chk("busy", busy, m_busy);
      chk("fill_done", fill_done, m_done);
      chk("overflow", overflow, m_ovf);
    end
    if (mem_we === 1'b1) obs.push_back(int'(mem_addr) * 8 + int'(mem_wdata));
    if (fill_done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_draw(input int x, input int y, input int c);
    draw_en    = 1'b1;
    draw_pos   = {10'(x), 10'(y)};
    draw_color = 3'(c);
  endtask

  int tmp, bad, prev_pos, prev_col, obs_at_rst;

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_overflow", overflow, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    mem_grant = 1'b1;
    cyc(2);

    // Single draw latency: x=5, y=2 -> 2*640+5 = 1285
    set_draw(5, 2, 6);
    @(negedge clk);
    draw_en = 1'b0;
    chk("t1_we_early", mem_we, 0);
    @(negedge clk);
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 1285);
    chk("t1_wdata", mem_wdata, 6);
    @(negedge clk);
    chk("t1_we_off", mem_we, 0);
    chk("t1_busy_off", busy, 0);

    // Out-of-range draws are discarded without overflow
    obs.delete();
    set_draw(640, 0, 2); @(negedge clk);
    set_draw(0, 480, 2); @(negedge clk);
    set_draw(0, 8, 2);   @(negedge clk);
    draw_en = 1'b0;
    cyc(4);
    chk("t2_no_writes", obs.size(), 0);
    chk("t2_overflow", overflow, 0);
    set_draw(639, 7, 3); @(negedge clk);
    draw_en = 1'b0;
    cyc(3);
    chk("t2_corner_cnt", obs.size(), 1);
    tmp = (obs.size() > 0) ? obs[0] : -1;
    chk("t2_corner", tmp, 5119 * 8 + 3);

    // Overflow: 17 draws with no grant, 16 survive in order
    obs.delete();
    mem_grant = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_draw(i, 1, i % 8);
      @(negedge clk);
    end
    draw_en = 1'b0;
    @(negedge clk);
    chk("t3_overflow", overflow, 1);
    chk("t3_held", obs.size(), 0);
    mem_grant = 1'b1;
    cyc(25);
    chk("t3_count", obs.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && i < obs.size(); i++)
      if (obs[i] != (640 + i) * 8 + (i % 8)) bad++;
    chk("t3_order", bad, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // Full fill, with a draw and an ignored fill_req injected mid-fill
    obs.delete();
    done_cnt = 0;
    fill_req = 1'b1; fill_color = 3'd1;
    @(negedge clk);
    fill_req = 1'b0; fill_color = 3'd0;
    @(negedge clk);
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_busy", busy, 1);
    cyc(50);
    set_draw(7, 3, 5); @(negedge clk);
    draw_en = 1'b0;
    cyc(20);
    fill_req = 1'b1; fill_color = 3'd2; @(negedge clk);
    fill_req = 1'b0;
    for (int i = 0; i < NPIX + 100 && done_cnt == 0; i++) @(negedge clk);
    cyc(5);
    chk("t4_done_once", done_cnt, 1);
    chk("t4_count", obs.size(), NPIX + 1);
    bad = 0;
    for (int i = 0; i < NPIX && i < obs.size(); i++)
      if (obs[i] != i * 8 + 1) bad++;
    chk("t4_fill_seq", bad, 0);
    tmp = (obs.size() > NPIX) ? obs[NPIX] : -1;
    chk("t4_tail", tmp, 1927 * 8 + 5);
    chk("t4_busy_off", busy, 0);

    // Grant toggling every cycle during a 4-draw burst
    obs.delete();
    for (int i = 0; i < 14; i++) begin
      mem_grant = 1'(i % 2);
      if (i < 4) set_draw(100 + i, 4, i + 1);
      else       draw_en = 1'b0;
      @(negedge clk);
    end
    mem_grant = 1'b1;
    cyc(3);
    chk("t5_count", obs.size(), 4);
    bad = 0;
    for (int i = 0; i < 4 && i < obs.size(); i++)
      if (obs[i] != (4 * 640 + 100 + i) * 8 + (i + 1)) bad++;
    chk("t5_order", bad, 0);

    // Reset mid-burst aborts pending writes
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      set_draw(200 + i, 5, 7);
      @(negedge clk);
    end
    draw_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5_rst_we", mem_we, 0);
    obs_at_rst = obs.size();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(10);
    chk("t5_no_more", obs.size(), obs_at_rst);
    chk("t5_partial", (obs_at_rst < 4) ? 1 : 0, 1);

    // Three identical draws while grant is low
    obs.delete();
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_draw(9, 6, 4);
      @(negedge clk);
    end
    draw_en = 1'b0;
    mem_grant = 1'b1;
    cyc(8);
`ifdef FB_WRITE_DEDUP_EN
    chk("t6_dedup", obs.size(), 1);
`else
    chk("t6_dedup", obs.size(), 3);
`endif

    // Randomized traffic checked cycle by cycle against the model
    prev_pos = 0; prev_col = 0;
    for (int i = 0; i < 4000; i++) begin
      mem_grant = ($urandom_range(0, 9) < 6);
      fill_req  = ($urandom_range(0, 1499) == 0);
      fill_color = 3'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 3) == 0) begin
          draw_en = 1'b1; draw_pos = 20'(prev_pos); draw_color = 3'(prev_col);
        end else begin
          set_draw($urandom_range(0, 645), $urandom_range(0, 9), $urandom_range(0, 7));
        end
      end else begin
        draw_en = 1'b0;
      end
      prev_pos = int'(draw_pos);
      prev_col = int'(draw_color);
      obs.delete();
      @(negedge clk);
    end
    draw_en = 1'b0; fill_req = 1'b0; mem_grant = 1'b1;
    for (int i = 0; i < NPIX + 100 && busy !== 1'b0; i++) @(negedge clk);
    chk("drain_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
